fnd_scan_ctrl: RTL

//  Drives the FND digit-select/enable interface of the calculator display path.

---
 rtl/fnd_scan_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: binary-to-BCD conversion (sequential double-dabble) plus a
// free-running 4-digit scan that drives the FND decoder with leading-zero blanking.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for i_load; display regs hold the last converted value
// ST_SHIFT | one double-dabble step per cycle, 14 steps total
// ST_DONE  | publish the BCD scratch to the display regs in one cycle
module fnd_scan_ctrl #(
  parameter int DIV     = 100_000,
  parameter int VALUE_W = 14
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_load,
  output logic               o_busy,
  output logic               o_ovf,
  output logic [1:0]         o_digitSelect,
  output logic [3:0]         o_bcd,
  output logic               o_en
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t            state_q;
  logic [13:0]       bin_q;
  logic [15:0]       bcd_q;
  logic [3:0]        cnt_q;
  logic [15:0]       digits_q;
  logic              busy_q;
  logic              ovf_q;
  logic [PRE_W-1:0]  pre_q;
  logic [1:0]        idx_q;
  logic [1:0]        sel_q;
  logic [3:0]        bcd_out_q;
  logic              en_q;

  logic              value_over;
  logic [13:0]       value_sat;
  logic [15:0]       bcd_adj;
  logic [3:0]        digit_d;
  logic [15:0]       upper_d;
  logic              en_d;

  // Saturate the incoming value to the 4-digit range (compare done wide so any VALUE_W works).
  assign value_over = (32'(i_value) > 32'd9999);
  assign value_sat  = value_over ? 14'd9999 : 14'(i_value);

  // Add-3 correction on every nibble that is 5 or more before the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end
  end

  // Digit for the current scan slot and its blanking decision: a slot is lit when it
  // is the units digit or when it or any more significant digit is non-zero.
  always_comb begin
    digit_d = digits_q[{idx_q, 2'b00} +: 4];
    upper_d = digits_q >> {idx_q, 2'b00};
    en_d    = (idx_q == 2'd0) || (upper_d != 16'd0);
  end

  // Conversion FSM; display regs only change in ST_DONE so the scan never sees a partial value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_load) begin
            bin_q   <= value_sat;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= value_over;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          digits_q <= bcd_q;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running prescaler and digit index, plus the registered scan outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q     <= '0;
      idx_q     <= '0;
      sel_q     <= '0;
      bcd_out_q <= '0;
      en_q      <= 1'b0;
    end else begin
      if (pre_q == PRE_TC) begin
        pre_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
      sel_q     <= idx_q;
      bcd_out_q <= digit_d;
      en_q      <= en_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_ovf         = ovf_q;
  assign o_digitSelect = sel_q;
  assign o_bcd         = bcd_out_q;
  assign o_en          = en_q;

endmodule
